uart_alu_frame_ctrl: RTL and testbench

- Framed command controller between the UART byte FIFOs and a parametrised-width ALU; successor to the single-byte UART/ALU interface.
- Receives one frame: sync, multi-byte operands A and B, opcode, XOR checksum.
- Drives the ALU, then returns a status byte plus the multi-byte result.
- Adds checksum and inter-byte timeout error handling, tx backpressure handling and error/frame counters.

---
 rtl/uart_alu_frame_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_uart_alu_frame_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_frame_ctrl
// Purpose  : Framed command controller between UART byte FIFOs and an ALU.
//            Frame in : SYNC, A (NBYTES, LSB first), B (NBYTES, LSB first),
//                       opcode, XOR checksum of A/B/opcode bytes.
//            Frame out: status byte (00 ok, 01 checksum, 02 timeout), then
//                       NBYTES result bytes LSB first when status is 00.
// Ports    : clk, reset (async active-low)
//            rx_empty/r_data/rd_uart   - rx FIFO (first-word fall-through)
//            tx_full/w_data/wr_uart    - tx FIFO
//            a/b/op -> ALU, res <- ALU (combinational)
//            busy, frame_cnt, err_cnt  - status and saturating counters
// Revision : 1.0 - initial framed release
// ============================================================================
module uart_alu_frame_ctrl #(
    parameter int              DBIT    = 8,
    parameter int              NBYTES  = 2,
    parameter logic [DBIT-1:0] SYNC    = 8'hA5,
    parameter int              TIMEOUT = 2000000,
    parameter int              TO_BIT  = 21
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_empty,
    input  logic [DBIT-1:0]        r_data,
    output logic                   rd_uart,
    input  logic                   tx_full,
    output logic                   wr_uart,
    output logic [DBIT-1:0]        w_data,
    output logic [DBIT*NBYTES-1:0] a,
    output logic [DBIT*NBYTES-1:0] b,
    output logic [DBIT-1:0]        op,
    input  logic [DBIT*NBYTES-1:0] res,
    output logic                   busy,
    output logic [7:0]             frame_cnt,
    output logic [7:0]             err_cnt
);

    localparam int              W        = DBIT * NBYTES;
    localparam int              IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT - 1);
    localparam logic [DBIT-1:0] ST_OK    = DBIT'(8'h00);
    localparam logic [DBIT-1:0] ST_CHK   = DBIT'(8'h01);
    localparam logic [DBIT-1:0] ST_TO    = DBIT'(8'h02);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        RX_A    = 4'd1,
        RX_B    = 4'd2,
        RX_OP   = 4'd3,
        RX_CHK  = 4'd4,
        EXEC    = 4'd5,
        TX_STAT = 4'd6,
        TX_RES  = 4'd7
    } state_t;

    state_t            state, state_nx;
    logic [IDX_W-1:0]  byte_idx;
    logic [DBIT-1:0]   chk;
    logic [DBIT-1:0]   status;
    logic [DBIT-1:0]   shadow_op;
    logic [W-1:0]      shadow_a, shadow_b, result;
    logic [TO_BIT-1:0] to_cnt;

    logic in_frame, pop, push, last_idx, timeout;

    // in_frame covers only the states where the inter-byte timer runs
    assign in_frame = (state == RX_A) || (state == RX_B) ||
                      (state == RX_OP) || (state == RX_CHK);
    // reset gates the pop strobe so it stays low while reset is asserted
    assign pop      = reset && !rx_empty && ((state == IDLE) || in_frame);
    assign push     = !tx_full && ((state == TX_STAT) || (state == TX_RES));
    assign last_idx = (byte_idx == LAST_IDX);
    // a byte present in the expiry cycle is consumed instead of timing out
    assign timeout  = in_frame && rx_empty && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rd_uart  = pop;
        wr_uart  = push;
        busy     = (state != IDLE);
        w_data   = '0;
        case (state)
            IDLE:    if (pop && (r_data == SYNC)) state_nx = RX_A;
            RX_A:    if (pop && last_idx) state_nx = RX_B;
                     else if (timeout)    state_nx = TX_STAT;
            RX_B:    if (pop && last_idx) state_nx = RX_OP;
                     else if (timeout)    state_nx = TX_STAT;
            RX_OP:   if (pop)             state_nx = RX_CHK;
                     else if (timeout)    state_nx = TX_STAT;
            RX_CHK:  if (pop)             state_nx = (r_data == chk) ? EXEC : TX_STAT;
                     else if (timeout)    state_nx = TX_STAT;
            EXEC:    state_nx = TX_STAT;
            TX_STAT: begin
                w_data = status;
                if (push) state_nx = (status == ST_OK) ? TX_RES : IDLE;
            end
            TX_RES: begin
                w_data = result[byte_idx*DBIT +: DBIT];
                if (push && last_idx) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx  <= '0;
            chk       <= '0;
            status    <= '0;
            shadow_a  <= '0;
            shadow_b  <= '0;
            shadow_op <= '0;
            result    <= '0;
            to_cnt    <= '0;
            a         <= '0;
            b         <= '0;
            op        <= '0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop && (r_data == SYNC)) begin
                        chk      <= '0;
                        byte_idx <= '0;
                        to_cnt   <= '0;
                    end
                end
                RX_A, RX_B, RX_OP, RX_CHK: begin
                    if (pop) begin
                        to_cnt <= '0;
                        case (state)
                            RX_A: begin
                                shadow_a[byte_idx*DBIT +: DBIT] <= r_data;
                                chk      <= chk ^ r_data;
                                byte_idx <= last_idx ? '0 : byte_idx + 1'b1;
                            end
                            RX_B: begin
                                shadow_b[byte_idx*DBIT +: DBIT] <= r_data;
                                chk      <= chk ^ r_data;
                                byte_idx <= last_idx ? '0 : byte_idx + 1'b1;
                            end
                            RX_OP: begin
                                shadow_op <= r_data;
                                chk       <= chk ^ r_data;
                            end
                            default: begin
                                // ALU operands are loaded here so res is
                                // already settled during the EXEC cycle
                                if (r_data == chk) begin
                                    a  <= shadow_a;
                                    b  <= shadow_b;
                                    op <= shadow_op;
                                end else begin
                                    status <= ST_CHK;
                                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                                end
                            end
                        endcase
                    end else if (timeout) begin
                        to_cnt <= '0;
                        status <= ST_TO;
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    result   <= res;
                    status   <= ST_OK;
                    byte_idx <= '0;
                    if (frame_cnt != 8'hFF) frame_cnt <= frame_cnt + 8'd1;
                end
                TX_RES: begin
                    if (push) byte_idx <= last_idx ? '0 : byte_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_alu_frame_ctrl
// Purpose  : Self-checking bench for uart_alu_frame_ctrl (NBYTES=2,
//            TIMEOUT=64). Behavioural rx/tx FIFOs and a small ALU
//            (0x20 ADD, 0x21 SUB, 0x22 AND, others XOR).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_alu_frame_ctrl;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_empty = 1'b1;
    logic [7:0]  r_data = 8'h00;
    logic        rd_uart, wr_uart, busy;
    logic        tx_full = 1'b0;
    logic [7:0]  w_data, op, frame_cnt, err_cnt;
    logic [15:0] a, b, res;

    uart_alu_frame_ctrl #(
        .DBIT(8), .NBYTES(2), .SYNC(8'hA5), .TIMEOUT(TO), .TO_BIT(21)
    ) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
        .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart),
        .w_data(w_data), .a(a), .b(b), .op(op), .res(res), .busy(busy),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (op)
            8'h20:   res = a + b;
            8'h21:   res = a - b;
            8'h22:   res = a & b;
            default: res = a ^ b;
        endcase
    end

    int         tests = 0;
    int         fails = 0;
    int         illegal = 0;
    int         cyc = 0;
    int         last_pop = -1;
    logic       hold_full = 1'b0;
    logic [7:0] last_wdata;
    logic       last_busy;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    int         txc[$];

    typedef struct {
        int               nrx;
        logic [11:0][7:0] rx;   // first byte at index nrx-1
        int               ntx;
        logic [2:0][7:0]  tx;   // first byte at index ntx-1
        logic [15:0]      ea, eb;
        logic [7:0]       eop, efc, eec;
        bit               good;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, sample strobes 1 ns later.
    task automatic tick();
        @(negedge clk);
        rx_empty = (rxq.size() == 0);
        r_data   = rx_empty ? 8'h00 : rxq[0];
        tx_full  = hold_full;
        #1;
        if (rd_uart && rx_empty) illegal++;
        if (rd_uart && wr_uart)  illegal++;
        if (wr_uart && tx_full)  illegal++;
        if (rd_uart) begin
            void'(rxq.pop_front());
            last_pop = cyc;
        end
        if (wr_uart) begin
            txq.push_back(w_data);
            txc.push_back(cyc);
        end
        last_wdata = w_data;
        last_busy  = busy;
        cyc++;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        txq.delete();
        txc.delete();
        for (int i = 0; i < v.nrx; i++) rxq.push_back(v.rx[v.nrx-1-i]);
        for (int i = 0; i < 30; i++) tick();
        check({tag, "_txcount"}, txq.size(), v.ntx);
        for (int i = 0; i < v.ntx && i < txq.size(); i++)
            check($sformatf("%s_tx%0d", tag, i), txq[i], v.tx[v.ntx-1-i]);
        check({tag, "_a"}, a, v.ea);
        check({tag, "_b"}, b, v.eb);
        check({tag, "_op"}, op, v.eop);
        check({tag, "_frame_cnt"}, frame_cnt, v.efc);
        check({tag, "_err_cnt"}, err_cnt, v.eec);
        check({tag, "_idle"}, last_busy, 1'b0);
        if (v.good && txc.size() == 3) begin
            check({tag, "_status_latency"}, txc[0] - last_pop, 2);
            check({tag, "_res_back2back"}, txc[2] - txc[0], 2);
        end
    endtask

    function automatic vec_t mk(input int nrx, input logic [11:0][7:0] rx,
                                input int ntx, input logic [2:0][7:0] tx,
                                input logic [15:0] ea, input logic [15:0] eb,
                                input logic [7:0] eop, input logic [7:0] efc,
                                input logic [7:0] eec, input bit good);
        vec_t v;
        v.nrx = nrx; v.rx = rx; v.ntx = ntx; v.tx = tx;
        v.ea = ea; v.eb = eb; v.eop = eop; v.efc = efc; v.eec = eec; v.good = good;
        return v;
    endfunction

    vec_t       good_add;
    int         bad_bp;

    initial begin
        // Frames execute in order; counters accumulate across rows.
        vecs[0] = mk(7, {8'hA5,8'h34,8'h12,8'h01,8'h00,8'h20,8'h07}, 3, {8'h00,8'h35,8'h12},
                     16'h1234, 16'h0001, 8'h20, 8'd1, 8'd0, 1'b1);
        vecs[1] = mk(7, {8'hA5,8'h00,8'h00,8'h00,8'h00,8'h20,8'h08}, 1, {8'h00,8'h00,8'h01},
                     16'h1234, 16'h0001, 8'h20, 8'd1, 8'd1, 1'b0);
        vecs[2] = mk(10, {8'h00,8'hFF,8'h5A,8'hA5,8'h34,8'h12,8'h01,8'h00,8'h20,8'h07}, 3,
                     {8'h00,8'h35,8'h12}, 16'h1234, 16'h0001, 8'h20, 8'd2, 8'd1, 1'b1);
        vecs[3] = mk(7, {8'hA5,8'h10,8'h00,8'h03,8'h00,8'h21,8'h32}, 3, {8'h00,8'h0D,8'h00},
                     16'h0010, 16'h0003, 8'h21, 8'd3, 8'd1, 1'b1);
        vecs[4] = mk(7, {8'hA5,8'h0F,8'hFF,8'hF0,8'h0F,8'h22,8'h2D}, 3, {8'h00,8'h00,8'h0F},
                     16'hFF0F, 16'h0FF0, 8'h22, 8'd4, 8'd1, 1'b1);
        vecs[5] = mk(7, {8'hA5,8'hFF,8'hFF,8'h02,8'h00,8'h20,8'h22}, 3, {8'h00,8'h01,8'h00},
                     16'hFFFF, 16'h0002, 8'h20, 8'd5, 8'd1, 1'b1);

        // Reset state with a byte waiting: nothing may be popped.
        rx_empty = 1'b0;
        r_data   = 8'h55;
        #12;
        check("rst_rd_uart", rd_uart, 1'b0);
        check("rst_wr_uart", wr_uart, 1'b0);
        check("rst_w_data", w_data, 8'h00);
        check("rst_a", a, 16'h0);
        check("rst_b", b, 16'h0);
        check("rst_op", op, 8'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_cnt", frame_cnt, 8'h0);
        check("rst_err_cnt", err_cnt, 8'h0);
        @(negedge clk);
        rx_empty = 1'b1;
        reset = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 6; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Inter-byte timeout after A5 34.
        txq.delete();
        txc.delete();
        rxq.push_back(8'hA5);
        rxq.push_back(8'h34);
        for (int i = 0; i < 120; i++) tick();
        check("to_txcount", txq.size(), 1);
        if (txq.size() > 0) begin
            check("to_status", txq[0], 8'h02);
            check("to_delay", txc[0] - last_pop, TO + 1);
        end
        check("to_idle", last_busy, 1'b0);
        check("to_err_cnt", err_cnt, 8'd2);
        check("to_a_kept", a, 16'hFFFF);
        good_add = vecs[0];
        good_add.efc = 8'd6;
        good_add.eec = 8'd2;
        apply_vec(good_add, "after_to");

        // Backpressure on TX_STAT.
        txq.delete();
        txc.delete();
        hold_full = 1'b1;
        for (int i = 0; i < 7; i++) rxq.push_back(vecs[0].rx[6-i]);
        for (int i = 0; i < 8; i++) tick();
        bad_bp = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (last_wdata !== 8'h00 || last_busy !== 1'b1) bad_bp++;
        end
        check("bp_no_write", txq.size(), 0);
        check("bp_w_data_hold", bad_bp, 0);
        hold_full = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("bp_txcount", txq.size(), 3);
        if (txq.size() == 3) begin
            check("bp_tx0", txq[0], 8'h00);
            check("bp_tx1", txq[1], 8'h35);
            check("bp_tx2", txq[2], 8'h12);
            check("bp_back2back", txc[2] - txc[0], 2);
        end
        check("bp_frame_cnt", frame_cnt, 8'd7);

        // Asynchronous reset mid-frame.
        txq.delete();
        rxq.push_back(8'hA5);
        rxq.push_back(8'h34);
        rxq.push_back(8'h12);
        for (int i = 0; i < 3; i++) tick();
        check("mid_busy", busy, 1'b1);
        @(negedge clk);
        rx_empty = 1'b0;
        r_data   = 8'h77;
        #3 reset = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_rd_uart", rd_uart, 1'b0);
        check("arst_a", a, 16'h0);
        check("arst_op", op, 8'h0);
        check("arst_frame_cnt", frame_cnt, 8'h0);
        check("arst_err_cnt", err_cnt, 8'h0);
        rxq.delete();
        tick();
        tick();
        @(negedge clk);
        reset = 1'b1;
        check("arst_no_tx", txq.size(), 0);
        apply_vec(vecs[0], "post_rst");

        check("strobe_rules", illegal, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
